sha256_msg_sched: RTL and testbench

SHA-256 message-schedule expander. Accepts one 512-bit message block and streams the 64 schedule words W[0..63] (FIPS 180-4 §6.2.2) to the compression round stage, one word per cycle under a valid/ready handshake. Internally it keeps a 16-word sliding window. It applies the combinational rotate/shift primitives (ROTR7, ROTR18, SHR3 for σ0; ROTR17, ROTR19, SHR10 for σ1) to generate W[16..63] on the fly.

---
 rtl/sha256_msg_sched.sv | 106 ++++++++++
 tb/tb_sha256_msg_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander.
// Loads one 512-bit block into a 16-word sliding window and streams
// W[0..ROUNDS-1] one word per accepted handshake. W[16..] are generated
// on the fly from the window as words are consumed.
// Optional feature macro: SHA256_SCHED_B2B_EN. When defined, a new block is
// accepted on the same edge as the last word, so there is no idle bubble
// between blocks.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no block held; blk_ready=1, w_valid=0
// RUN   | window holds W[t..t+15]; w_valid=1, w_data=W[t]
module sha256_msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sched_clr,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_idx,
    output logic         w_last
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    logic [0:0]  r_state;
    logic [5:0]  r_t;
    logic [31:0] r_win [16];

    logic        w_run;
    logic        w_at_last;
    logic        w_word_fire;
    logic        w_blk_fire;
    logic [31:0] w_next;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    assign w_run     = (r_state == ST_RUN);
    assign w_at_last = (r_t == LAST_IDX);

    assign w_valid = w_run;
    assign w_data  = r_win[0];
    assign w_idx   = r_t;
    assign w_last  = w_run & w_at_last;

`ifdef SHA256_SCHED_B2B_EN
    // In RUN the next block may enter exactly when the last word leaves.
    assign blk_ready = ~w_run | (w_ready & w_at_last);
`else
    assign blk_ready = ~w_run;
`endif

    // sched_clr suppresses both handshakes for the cycle it is high.
    assign w_word_fire = w_run & w_ready & ~sched_clr;
    assign w_blk_fire  = blk_valid & blk_ready & ~sched_clr;

    // Next schedule word; sum wraps mod 2^32.
    assign w_next = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

    // State and round index; a block load wins over the final word accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
        end else if (sched_clr) begin
            r_state <= ST_IDLE;
            r_t     <= '0;
        end else if (w_blk_fire) begin
            r_state <= ST_RUN;
            r_t     <= '0;
        end else if (w_word_fire) begin
            if (w_at_last) begin
                r_state <= ST_IDLE;
                r_t     <= '0;
            end else begin
                r_t <= r_t + 6'd1;
            end
        end
    end

    // Window: parallel load of the block, or shift by one word on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_win[i] <= '0;
        end else if (w_blk_fire) begin
            for (int i = 0; i < 16; i++) r_win[i] <= blk_data[511 - 32*i -: 32];
        end else if (w_word_fire) begin
            for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
            r_win[15] <= w_next;
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Self-checking bench for sha256_msg_sched: behavioural model of the full
// 64-word schedule plus directed scenarios (abc vector, back-to-back blocks,
// abort, mid-stream reset, ROUNDS=16 instance).
`timescale 1ns/1ps
module tb_sha256_msg_sched;

    localparam int R = 64;
`ifdef SHA256_SCHED_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sched_clr, blk_valid, blk_ready, w_valid, w_ready, w_last;
    logic [511:0] blk_data;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;

    logic         s_blk_valid, s_blk_ready, s_w_valid, s_w_ready, s_w_last;
    logic [511:0] s_blk_data;
    logic [31:0]  s_w_data;
    logic [5:0]   s_w_idx;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sha256_msg_sched #(.ROUNDS(R)) u_dut (
        .clk(clk), .rst_n(rst_n), .sched_clr(sched_clr),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_idx(w_idx), .w_last(w_last)
    );

    sha256_msg_sched #(.ROUNDS(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .sched_clr(1'b0),
        .blk_valid(s_blk_valid), .blk_ready(s_blk_ready), .blk_data(s_blk_data),
        .w_valid(s_w_valid), .w_ready(s_w_ready), .w_data(s_w_data),
        .w_idx(s_w_idx), .w_last(s_w_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] s0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] sched_word(input logic [511:0] b, input int t);
        logic [31:0] w [64];
        for (int i = 0; i < 64; i++) begin
            if (i < 16) w[i] = b[511 - 32*i -: 32];
            else        w[i] = s1(w[i-2]) + w[i-7] + s0(w[i-15]) + w[i-16];
        end
        return w[t];
    endfunction

    function automatic bit exp_rdy(input bit run, input int t, input logic wr);
        return !run || (B2B && (wr === 1'b1) && t == R-1);
    endfunction

    logic [511:0] m_blk = '0;
    bit           m_run = 1'b0;
    int           m_t   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_t = 0;
        end else if (sched_clr) begin
            m_run = 1'b0; m_t = 0;
        end else if (blk_valid && exp_rdy(m_run, m_t, w_ready)) begin
            m_blk = blk_data; m_run = 1'b1; m_t = 0;
        end else if (m_run && w_ready) begin
            if (m_t == R-1) begin m_run = 1'b0; m_t = 0; end
            else m_t++;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] p_data;
    logic [5:0]  p_idx;
    bit          p_stall = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("blk_ready", blk_ready, exp_rdy(m_run, m_t, w_ready));
            chk("w_valid", w_valid, m_run);
            if (m_run) begin
                chk("w_data", w_data, sched_word(m_blk, m_t));
                chk("w_idx", w_idx, m_t);
                chk("w_last", w_last, m_t == R-1);
            end
            if (p_stall) begin
                chk("stall_valid", w_valid, 1'b1);
                chk("stall_data", w_data, p_data);
                chk("stall_idx", w_idx, p_idx);
            end
            p_stall = w_valid && !w_ready && !sched_clr;
            p_data  = w_data;
            p_idx   = w_idx;
        end else begin
            p_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [511:0] b);
        bit got = 1'b0;
        blk_valid = 1'b1;
        blk_data  = b;
        for (int i = 0; i < 300 && !got; i++) begin
            if (blk_ready) got = 1'b1;
            cyc();
        end
        blk_valid = 1'b0;
        chk("blk_accept_timeout", got, 1'b1);
    endtask

    task automatic drain(input bit bp);
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!w_valid) done = 1'b1;
            else cyc();
        end
        chk("drain_timeout", done, 1'b1);
        w_ready = 1'b0;
    endtask

    task automatic run_to(input int idx);
        bit hit = 1'b0;
        w_ready = 1'b1;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (w_valid && w_idx == 6'(idx)) hit = 1'b1;
            else cyc();
        end
        chk("run_to_timeout", hit, 1'b1);
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = $urandom;
        return b;
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [511:0] abc, ba, bb, rb;
        int nwords, last_idx, gap, accepts;
        bit seen, done;

        rst_n = 1'b0; sched_clr = 1'b0; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
        s_blk_valid = 1'b0; s_blk_data = '0; s_w_ready = 1'b0;
        #2;
        chk("rst_blk_ready", blk_ready, 1'b1);
        chk("rst_w_valid", w_valid, 1'b0);
        chk("rst_w_data", w_data, 32'h0);
        chk("rst_w_idx", w_idx, 6'd0);
        chk("rst_w_last", w_last, 1'b0);

        abc = {32'h61626380, 448'd0, 32'h00000018};
        chk("model_w0", sched_word(abc, 0), 32'h61626380);
        chk("model_w15", sched_word(abc, 15), 32'h00000018);
        chk("model_w16", sched_word(abc, 16), 32'h61626380);
        chk("model_w17", sched_word(abc, 17), 32'h000F0000);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // "abc" vector with no backpressure
        send_block(abc);
        w_ready = 1'b1; nwords = 0; last_idx = -1;
        for (int i = 0; i < 200 && w_valid; i++) begin
            if (w_idx == 6'd0)  chk("abc_w0", w_data, 32'h61626380);
            if (w_idx == 6'd15) chk("abc_w15", w_data, 32'h00000018);
            if (w_idx == 6'd16) chk("abc_w16", w_data, 32'h61626380);
            if (w_idx == 6'd17) chk("abc_w17", w_data, 32'h000F0000);
            if (w_last) last_idx = int'(w_idx);
            nwords++;
            cyc();
        end
        w_ready = 1'b0;
        chk("abc_count", nwords, 64);
        chk("abc_last_idx", last_idx, 63);
        chk("abc_idle_ready", blk_ready, 1'b1);

        // random blocks under random backpressure
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 3)) cyc();
            send_block(rand_block());
            drain(1'b1);
        end

        // two blocks offered back-to-back
        ba = rand_block(); bb = rand_block();
        blk_data = ba; blk_valid = 1'b1; w_ready = 1'b1;
        accepts = 0; gap = 0; seen = 1'b0; done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (w_valid && w_last && !seen) seen = 1'b1;
            else if (seen && !w_valid) gap++;
            else if (seen && w_valid && w_idx == 6'd0) done = 1'b1;
            if (blk_valid && blk_ready) accepts++;
            cyc();
            if (accepts == 1) blk_data = bb;
            if (accepts >= 2) blk_valid = 1'b0;
        end
        chk("b2b_done", done, 1'b1);
        chk("b2b_gap", gap, B2B ? 0 : 1);
        blk_valid = 1'b0;
        drain(1'b0);

        // abort at w_idx=20
        send_block(rand_block());
        run_to(20);
        sched_clr = 1'b1;
        cyc();
        sched_clr = 1'b0;
        chk("clr_w_valid", w_valid, 1'b0);
        chk("clr_blk_ready", blk_ready, 1'b1);
        blk_valid = 1'b1; blk_data = rand_block(); sched_clr = 1'b1;
        cyc();
        sched_clr = 1'b0; blk_valid = 1'b0;
        chk("clr_blocks_load", w_valid, 1'b0);
        rb = rand_block();
        send_block(rb);
        chk("clr_restart_idx", w_idx, 6'd0);
        chk("clr_restart_w0", w_data, rb[511:480]);
        drain(1'b1);

        // reset at w_idx=40
        send_block(rand_block());
        run_to(40);
        rst_n = 1'b0;
        #1;
        chk("arst_w_valid", w_valid, 1'b0);
        chk("arst_w_data", w_data, 32'h0);
        chk("arst_w_idx", w_idx, 6'd0);
        chk("arst_w_last", w_last, 1'b0);
        chk("arst_blk_ready", blk_ready, 1'b1);
        w_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        chk("post_rst_w_valid", w_valid, 1'b0);
        send_block(rand_block());
        drain(1'b1);

        // ROUNDS=16 instance
        rb = rand_block();
        s_blk_data = rb; s_blk_valid = 1'b1;
        cyc();
        s_blk_valid = 1'b0; s_w_ready = 1'b1;
        nwords = 0; last_idx = -1;
        for (int i = 0; i < 100 && s_w_valid; i++) begin
            chk("r16_idx", s_w_idx, 6'(nwords));
            chk("r16_data", s_w_data, rb[511 - 32*nwords -: 32]);
            chk("r16_last", s_w_last, nwords == 15);
            if (s_w_last) last_idx = int'(s_w_idx);
            nwords++;
            cyc();
        end
        chk("r16_count", nwords, 16);
        chk("r16_last_idx", last_idx, 15);
        chk("r16_idle_ready", s_blk_ready, 1'b1);

        cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
